// File: rtl/noc_packet_injector_pkg.sv
// Shared types for the NoC packet injector.
//  - Noc_ID_X_Width / Noc_ID_Y_Width : mesh coordinate widths
//  - noc_flit_type_e                  : 2-bit flit type carried in the flit MSBs
//  - noc_head_t                       : coordinate fields of a head flit, dst_x in the LSBs
//  - inj_state_e                      : injector control states
//  - make_head()                      : packs source/destination coordinates into noc_head_t
package noc_packet_injector_pkg;

    localparam int Noc_ID_X_Width = 4;
    localparam int Noc_ID_Y_Width = 4;

    typedef enum logic [1:0] {
        FLIT_HEAD      = 2'b00,
        FLIT_BODY      = 2'b01,
        FLIT_TAIL      = 2'b10,
        FLIT_HEAD_TAIL = 2'b11
    } noc_flit_type_e;

    // The length field sits above this struct in the head flit; it is
    // added by the top because its width is a module parameter.
    typedef struct packed {
        logic [Noc_ID_Y_Width-1:0] src_y;
        logic [Noc_ID_X_Width-1:0] src_x;
        logic [Noc_ID_Y_Width-1:0] dst_y;
        logic [Noc_ID_X_Width-1:0] dst_x;
    } noc_head_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEAD    = 2'd1,
        ST_PAYLOAD = 2'd2
    } inj_state_e;

    function automatic noc_head_t make_head(
        input logic [Noc_ID_X_Width-1:0] src_x,
        input logic [Noc_ID_Y_Width-1:0] src_y,
        input logic [Noc_ID_X_Width-1:0] dst_x,
        input logic [Noc_ID_Y_Width-1:0] dst_y
    );
        noc_head_t h;
        h.src_y = src_y;
        h.src_x = src_x;
        h.dst_y = dst_y;
        h.dst_x = dst_x;
        return h;
    endfunction

endpackage

// File: rtl/noc_flit_out_reg.sv
// One-entry valid/ready output register.
//  clk, srst   : clock, synchronous active-high reset (clears valid and data)
//  load_valid  : load load_data this cycle (only honoured when can_load=1)
//  load_data   : word to register
//  can_load    : register empty, or its word is handshaking this cycle
//  out_valid   : registered word valid
//  out_data    : registered word, stable while out_valid && !out_ready
//  out_ready   : downstream accepts out_data
module noc_flit_out_reg #(
    parameter int WIDTH = 35
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             can_load,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;

    // A new word may replace the current one in the cycle it drains,
    // which gives one word per cycle without a second entry.
    assign can_load  = !valid_reg || out_ready;
    assign out_valid = valid_reg;
    assign out_data  = data_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (load_valid && can_load) begin
            valid_reg <= 1'b1;
            data_reg  <= load_data;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/noc_packet_injector.sv
// Node-side packet injector: turns a packet request plus a payload word
// stream into HEAD/BODY/TAIL (or single HEAD_TAIL) flits for the local
// port of a mesh router.
//  noc_clk, noc_rst        : clock, synchronous active-high reset
//  id_x, id_y              : own coordinates, written into the head as source
//  req_*                   : packet request (destination, VC, payload length)
//  data_valid/ready, data  : payload word stream
//  flit_valid/ready        : flit handshake toward the fabric
//  flit_vc, flit           : VC and {type, body} of the current flit
//  vc_ready                : per-VC buffer space at the fabric input
module noc_packet_injector
    import noc_packet_injector_pkg::*;
#(
    parameter int VC_NUM     = 2,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 5,
    parameter int FLIT_WIDTH = DATA_WIDTH + 2
) (
    input  logic                        noc_clk,
    input  logic                        noc_rst,
    input  logic [Noc_ID_X_Width-1:0]   id_x,
    input  logic [Noc_ID_Y_Width-1:0]   id_y,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [Noc_ID_X_Width-1:0]   req_dst_x,
    input  logic [Noc_ID_Y_Width-1:0]   req_dst_y,
    input  logic [$clog2(VC_NUM)-1:0]   req_vc,
    input  logic [LEN_WIDTH-1:0]        req_len,
    input  logic                        data_valid,
    output logic                        data_ready,
    input  logic [DATA_WIDTH-1:0]       data,
    output logic                        flit_valid,
    input  logic                        flit_ready,
    output logic [$clog2(VC_NUM)-1:0]   flit_vc,
    output logic [FLIT_WIDTH-1:0]       flit,
    input  logic [VC_NUM-1:0]           vc_ready
);

    localparam int VC_WIDTH  = $clog2(VC_NUM);
    localparam int HEAD_BITS = LEN_WIDTH + $bits(noc_head_t);

    inj_state_e                state_reg;
    logic                      req_ready_reg;
    logic [Noc_ID_X_Width-1:0] dst_x_reg;
    logic [Noc_ID_Y_Width-1:0] dst_y_reg;
    logic [VC_WIDTH-1:0]       vc_reg;
    logic [LEN_WIDTH-1:0]      len_reg;
    logic [LEN_WIDTH-1:0]      remaining_reg;

    logic                      can_load;
    logic                      vc_open;
    logic [VC_NUM-1:0]         vc_hit;
    logic                      head_load;
    logic                      word_load;
    logic                      last_drain;
    logic                      load_valid;
    noc_flit_type_e            load_type;
    logic [DATA_WIDTH-1:0]     load_body;
    logic [HEAD_BITS-1:0]      head_bits;
    logic [DATA_WIDTH-1:0]     head_word;
    logic [FLIT_WIDTH+VC_WIDTH-1:0] out_data;

    // Space check for the latched VC only; the fabric's other VCs are irrelevant.
    for (genvar gi = 0; gi < VC_NUM; gi++) begin : g_vc_hit
        assign vc_hit[gi] = vc_ready[gi] && (vc_reg == VC_WIDTH'(gi));
    end
    assign vc_open = |vc_hit;

    assign head_bits = {len_reg, make_head(id_x, id_y, dst_x_reg, dst_y_reg)};
    assign head_word = DATA_WIDTH'(head_bits);

    // vc_ready only gates loading; a flit already in the output register stays put.
    assign head_load  = (state_reg == ST_HEAD) && can_load && vc_open;
    // remaining_reg reaches 0 once the last word is loaded; after that the
    // payload phase only waits for that final flit to drain.
    assign data_ready = (state_reg == ST_PAYLOAD) && (remaining_reg != '0) && can_load && vc_open;
    assign word_load  = data_ready && data_valid;
    assign last_drain = (state_reg == ST_PAYLOAD) && (remaining_reg == '0) && flit_valid && flit_ready;
    assign load_valid = head_load || word_load;
    assign req_ready  = req_ready_reg;

    always_comb begin
        load_type = FLIT_BODY;
        load_body = data;
        if (head_load) begin
            load_type = (len_reg == '0) ? FLIT_HEAD_TAIL : FLIT_HEAD;
            load_body = head_word;
        end else if (remaining_reg == LEN_WIDTH'(1)) begin
            load_type = FLIT_TAIL;
        end
    end

    noc_flit_out_reg #(
        .WIDTH(FLIT_WIDTH + VC_WIDTH)
    ) u_out_reg (
        .clk        (noc_clk),
        .srst       (noc_rst),
        .load_valid (load_valid),
        .load_data  ({vc_reg, load_type, load_body}),
        .can_load   (can_load),
        .out_valid  (flit_valid),
        .out_data   (out_data),
        .out_ready  (flit_ready)
    );

    assign {flit_vc, flit} = out_data;

    // Head-only packets also pass through ST_PAYLOAD (remaining=0) so every
    // packet leaves through the same "last flit drained" exit.
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            state_reg     <= ST_IDLE;
            req_ready_reg <= 1'b0;
            dst_x_reg     <= '0;
            dst_y_reg     <= '0;
            vc_reg        <= '0;
            len_reg       <= '0;
            remaining_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid && req_ready_reg) begin
                        dst_x_reg     <= req_dst_x;
                        dst_y_reg     <= req_dst_y;
                        vc_reg        <= req_vc;
                        len_reg       <= req_len;
                        remaining_reg <= req_len;
                        req_ready_reg <= 1'b0;
                        state_reg     <= ST_HEAD;
                    end else begin
                        req_ready_reg <= 1'b1;
                    end
                end
                ST_HEAD: begin
                    if (head_load) begin
                        state_reg <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (word_load) begin
                        remaining_reg <= remaining_reg - LEN_WIDTH'(1);
                    end
                    if (last_drain) begin
                        state_reg     <= ST_IDLE;
                        req_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noc_packet_injector.sv
module tb_noc_packet_injector;
    import noc_packet_injector_pkg::*;

    localparam int ID_X = 3;
    localparam int ID_Y = 2;

    logic        noc_clk = 1'b0;
    logic        noc_rst = 1'b1;
    logic [3:0]  id_x, id_y;
    logic        req_valid, req_ready;
    logic [3:0]  req_dst_x, req_dst_y;
    logic [0:0]  req_vc;
    logic [4:0]  req_len;
    logic        data_valid, data_ready;
    logic [31:0] data;
    logic        flit_valid, flit_ready;
    logic [0:0]  flit_vc;
    logic [33:0] flit;
    logic [1:0]  vc_ready;

    typedef struct {
        logic [1:0]  t;
        logic [31:0] body;
        logic        vc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] data_q[$];
    int          hs_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          fr_pct = 100;
    int          dv_pct = 100;
    bit          vc_rand = 1'b0;
    logic [1:0]  vc_force = 2'b11;
    int          pkt_no = 0;

    noc_packet_injector dut (
        .noc_clk    (noc_clk),
        .noc_rst    (noc_rst),
        .id_x       (id_x),
        .id_y       (id_y),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_dst_x  (req_dst_x),
        .req_dst_y  (req_dst_y),
        .req_vc     (req_vc),
        .req_len    (req_len),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .data       (data),
        .flit_valid (flit_valid),
        .flit_ready (flit_ready),
        .flit_vc    (flit_vc),
        .flit       (flit),
        .vc_ready   (vc_ready)
    );

    always #5 noc_clk = ~noc_clk;
    always @(posedge noc_clk) cyc <= cyc + 1;

    // Fabric side: drives flit_ready/vc_ready, pops the scoreboard on every
    // flit handshake and checks that a stalled flit does not change.
    initial begin
        bit          held_v;
        logic [33:0] held_f;
        logic        held_vc;
        exp_t        e;
        held_v = 1'b0;
        flit_ready = 1'b0;
        vc_ready = 2'b11;
        forever begin
            @(negedge noc_clk);
            flit_ready = ($urandom_range(0, 99) < fr_pct);
            vc_ready = vc_rand ? {1'($urandom_range(0, 99) < 80), 1'($urandom_range(0, 99) < 80)} : vc_force;
            #1;
            if (noc_rst) begin
                held_v = 1'b0;
            end else begin
                if (held_v) begin
                    checks++;
                    if (!(flit_valid === 1'b1 && flit === held_f && flit_vc === held_vc)) begin
                        failures++;
                        $display("FAIL hold_stable: got valid=%0b flit=%h vc=%0d, required valid=1 flit=%h vc=%0d",
                                 flit_valid, flit, flit_vc, held_f, held_vc);
                    end
                end
                if (flit_valid && flit_ready) begin
                    checks++;
                    hs_q.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_flit: got flit=%h vc=%0d, required no flit", flit, flit_vc);
                    end else begin
                        e = exp_q.pop_front();
                        if (flit !== {e.t, e.body} || flit_vc !== e.vc) begin
                            failures++;
                            $display("FAIL flit_compare: got flit=%h vc=%0d, required flit=%h vc=%0d",
                                     flit, flit_vc, {e.t, e.body}, e.vc);
                        end
                    end
                end
                held_v  = flit_valid && !flit_ready;
                held_f  = flit;
                held_vc = flit_vc;
            end
        end
    end

    // Payload source: presents queued words, drops a word only when consumed.
    initial begin
        data_valid = 1'b0;
        data = '0;
        forever begin
            @(negedge noc_clk);
            if (!noc_rst && data_q.size() > 0 && $urandom_range(0, 99) < dv_pct) begin
                data_valid = 1'b1;
                data = data_q[0];
            end else begin
                data_valid = 1'b0;
                data = $urandom;
            end
            #1;
            if (!noc_rst && data_valid && data_ready) void'(data_q.pop_front());
        end
    end

    task automatic tick();
        @(negedge noc_clk);
        #3;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Reference model: expected flits follow directly from the packet format.
    task automatic send_pkt(input int dx, input int dy, input int vc, input int len, input bit seq);
        exp_t        e;
        logic [31:0] w;
        int          n;
        e.vc   = vc[0];
        e.t    = (len == 0) ? 2'b11 : 2'b00;
        e.body = 32'((len << 16) | (ID_Y << 12) | (ID_X << 8) | (dy << 4) | dx);
        exp_q.push_back(e);
        for (int i = 0; i < len; i++) begin
            w = seq ? 32'(32'hA + i) : 32'($urandom);
            data_q.push_back(w);
            e.t    = (i == len - 1) ? 2'b10 : 2'b01;
            e.body = w;
            exp_q.push_back(e);
        end
        pkt_no++;
        $display("req %0d: dst=(%0d,%0d) vc=%0d len=%0d", pkt_no, dx, dy, vc, len);
        req_valid = 1'b1;
        req_dst_x = dx[3:0];
        req_dst_y = dy[3:0];
        req_vc    = vc[0:0];
        req_len   = len[4:0];
        n = 0;
        while (!req_ready && n < 1000) begin
            tick();
            n++;
        end
        chk("req_accepted", req_ready, 1);
        if (req_ready) begin
            @(posedge noc_clk);
            #1;
        end
        req_valid = 1'b0;
        tick();
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        chk("drain_pending_flits", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        int span;
        id_x = 4'(ID_X);
        id_y = 4'(ID_Y);
        req_valid = 1'b0;
        req_dst_x = '0;
        req_dst_y = '0;
        req_vc    = '0;
        req_len   = '0;
        noc_rst   = 1'b1;
        repeat (3) tick();
        chk("rst_flit_valid", flit_valid, 0);
        chk("rst_flit", flit, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_data_ready", data_ready, 0);
        noc_rst = 1'b0;

        // Reset in the middle of a packet.
        fr_pct = 50;
        send_pkt(5, 6, 0, 8, 1'b0);
        repeat (6) tick();
        noc_rst = 1'b1;
        exp_q.delete();
        data_q.delete();
        repeat (3) tick();
        chk("midrst_flit_valid", flit_valid, 0);
        chk("midrst_flit", flit, 0);
        chk("midrst_flit_vc", flit_vc, 0);
        chk("midrst_req_ready", req_ready, 0);
        chk("midrst_data_ready", data_ready, 0);
        noc_rst = 1'b0;
        fr_pct = 100;

        // Head-only packet.
        send_pkt(2, 1, 1, 0, 1'b0);
        wait_drain(50);

        // Three payload words at full rate must leave on consecutive cycles.
        hs_q.delete();
        send_pkt(7, 5, 0, 3, 1'b1);
        wait_drain(50);
        chk("b2b_flit_count", hs_q.size(), 4);
        span = (hs_q.size() >= 4) ? hs_q[3] - hs_q[0] : -1;
        chk("b2b_cycle_span", span, 3);

        // Fabric stalls a body flit for four cycles.
        fr_pct = 0;
        send_pkt(1, 2, 0, 2, 1'b0);
        n = 0;
        while (!flit_valid && n < 50) begin
            tick();
            n++;
        end
        chk("stall_head_valid", flit_valid, 1);
        chk("stall_head_type", flit[33:32], 2'b00);
        fr_pct = 100;
        tick();
        fr_pct = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_body_valid", flit_valid, 1);
            chk("stall_body_type", flit[33:32], 2'b01);
            chk("stall_data_ready", data_ready, 0);
        end
        fr_pct = 100;
        wait_drain(50);

        // No buffer space on the packet's VC: head must wait.
        vc_force = 2'b01;
        send_pkt(3, 3, 1, 1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("vc_gate_flit_valid", flit_valid, 0);
        end
        vc_force = 2'b11;
        tick();
        tick();
        chk("vc_open_flit_valid", flit_valid, 1);
        chk("vc_open_flit_type", flit[33:32], 2'b00);
        chk("vc_open_flit_vc", flit_vc, 1);
        wait_drain(50);

        // Two requests back to back on different VCs.
        send_pkt(4, 0, 0, 1, 1'b0);
        send_pkt(0, 4, 1, 1, 1'b0);
        wait_drain(50);

        // Randomised traffic with random backpressure and VC space.
        fr_pct  = 70;
        dv_pct  = 70;
        vc_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send_pkt(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 1'b0);
        end
        wait_drain(5000);
        chk("payload_all_consumed", data_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
